// File: rtl/iso7816_pkg.sv
// rtl/iso7816_pkg.sv - shared line levels, receiver state encoding and parity helper
package iso7816_pkg;

   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;
   localparam int   BITCNT_W  = 4;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_PARITY,
      RX_STOP1,
      RX_STOP2,
      RX_NACK
   } rx_state_e;

   // Expected parity bit for up to 9 data bits (narrower characters are zero-extended).
   function automatic logic parity_bit(input logic [8:0] data, input logic odd);
      return (^data) ^ odd;
   endfunction

endpackage

// File: rtl/iso_rx_fifo.sv
// rtl/iso_rx_fifo.sv - synchronous first-word-fall-through receive FIFO with level output
module iso_rx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                             clk,
   input  logic                             nReset,
   input  logic                             push_i,
   input  logic [WIDTH-1:0]                 data_i,
   input  logic                             pop_i,
   output logic [WIDTH-1:0]                 data_o,
   output logic                             valid_o,
   output logic [$clog2(DEPTH+1)-1:0]       level_o,
   output logic                             overrun_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_q, rd_q;
   logic [LW-1:0]    count_q;
   logic [WIDTH-1:0] hold_q;
   logic             empty, full, pop_ok, push_ok;

   assign empty     = (count_q == '0);
   assign full      = (count_q == LW'(DEPTH));
   assign pop_ok    = pop_i && !empty;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
   assign push_ok   = push_i && (!full || pop_ok);
   assign overrun_o = push_i && full && !pop_ok;

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_q] <= data_i;
      end
   end

   always_ff @(posedge clk) begin
      if (!nReset) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
         hold_q  <= '0;
      end else begin
         if (push_ok) begin
            wr_q <= wr_q + 1'b1;
         end
         if (pop_ok) begin
            rd_q   <= rd_q + 1'b1;
            hold_q <= mem_q[rd_q];
         end
         case ({push_ok, pop_ok})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // When empty the last popped head is presented instead of a stale slot.
   assign data_o  = empty ? hold_q : mem_q[rd_q];
   assign valid_o = !empty;
   assign level_o = count_q;

endmodule

// File: rtl/iso_rx_fifo_core.sv
// rtl/iso_rx_fifo_core.sv - ISO7816-3 character receiver with prescaler, T=0 error signal and receive FIFO
module iso_rx_fifo_core
   import iso7816_pkg::*;
#(
   parameter int DIVIDER_WIDTH       = 1,
   parameter int CLOCK_PER_BIT_WIDTH = 13,
   parameter int DATA_WIDTH          = 8,
   parameter int FIFO_DEPTH          = 4
) (
   input  logic                                 clk,
   input  logic                                 nReset,
   input  logic [DIVIDER_WIDTH-1:0]             clkPerCycle,
   input  logic [CLOCK_PER_BIT_WIDTH-1:0]       clocksPerBit,
   input  logic                                 stopBit2,
   input  logic                                 oddParity,
   input  logic                                 msbFirst,
   input  logic                                 nackEnable,
   input  logic                                 serialIn,
   output logic                                 serialNackOut,
   input  logic                                 rdEn,
   output logic [DATA_WIDTH-1:0]                dataOut,
   output logic                                 dataValid,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifoLevel,
   input  logic                                 ackFlags,
   output logic                                 overrunErrorFlag,
   output logic                                 parityErrorFlag,
   output logic                                 frameErrorFlag,
   output logic                                 run,
   output logic                                 startBit,
   output logic                                 endOfRx
);

   localparam int CW = CLOCK_PER_BIT_WIDTH;

   logic [DIVIDER_WIDTH-1:0] presc_q;
   logic [1:0]               sync_q;
   logic                     tick, line;

   rx_state_e                state_q, state_d;
   logic [CW-1:0]            cnt_q, cnt_d;
   logic [BITCNT_W-1:0]      bitn_q, bitn_d;
   logic [DATA_WIDTH-1:0]    shift_q, shift_d;
   logic                     par_err_q, par_err_d;
   logic                     run_q, run_d;
   logic                     start_bit_q, start_bit_d;
   logic                     eor_q, eor_d;
   logic                     nack_q, nack_d;
   logic                     ovr_q, par_q, frm_q;
   logic [CW-1:0]            cpb_q;
   logic                     stop2_q, odd_q, msb_q, nacken_q;
   logic                     load_cfg, push, par_set, frm_set, ovr_set;
   logic                     sample, cnt_last;

   assign tick = (presc_q == clkPerCycle);
   assign line = sync_q[1];

   // Synchroniser resets to the idle level so reset never fakes a start edge.
   always_ff @(posedge clk) begin
      if (!nReset) begin
         presc_q <= '0;
         sync_q  <= {2{STOP_BIT}};
      end else begin
         presc_q <= tick ? '0 : presc_q + 1'b1;
         sync_q  <= {sync_q[0], serialIn};
      end
   end

   assign sample   = tick && (cnt_q == (cpb_q >> 1));
   assign cnt_last = (cnt_q == cpb_q - 1'b1);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bitn_d      = bitn_q;
      shift_d     = shift_q;
      par_err_d   = par_err_q;
      run_d       = run_q;
      start_bit_d = start_bit_q;
      eor_d       = 1'b0;
      nack_d      = nack_q;
      push        = 1'b0;
      par_set     = 1'b0;
      frm_set     = 1'b0;
      load_cfg    = 1'b0;
      if (tick) begin
         cnt_d = cnt_last ? '0 : cnt_q + 1'b1;
      end
      case (state_q)
         RX_IDLE: begin
            cnt_d = '0;
            if (line == START_BIT) begin
               state_d     = RX_START;
               start_bit_d = 1'b1;
               load_cfg    = 1'b1;
               par_err_d   = 1'b0;
               bitn_d      = '0;
            end
         end
         RX_START: begin
            if (sample) begin
               start_bit_d = 1'b0;
               if (line != START_BIT) begin
                  state_d = RX_IDLE;
               end else begin
                  state_d = RX_DATA;
                  run_d   = 1'b1;
               end
            end
         end
         RX_DATA: begin
            if (sample) begin
               shift_d = msb_q ? {shift_q[DATA_WIDTH-2:0], line} : {line, shift_q[DATA_WIDTH-1:1]};
               bitn_d  = bitn_q + 1'b1;
               if (bitn_q == BITCNT_W'(DATA_WIDTH - 1)) begin
                  state_d = RX_PARITY;
               end
            end
         end
         RX_PARITY: begin
            if (sample) begin
               state_d = RX_STOP1;
               if (line != parity_bit(9'(shift_q), odd_q)) begin
                  par_err_d = 1'b1;
                  par_set   = 1'b1;
               end
            end
         end
         RX_STOP1: begin
            if (sample) begin
               state_d = RX_IDLE;
               eor_d   = 1'b1;
               run_d   = 1'b0;
               if (par_err_q) begin
                  if (nacken_q) begin
                     // The error signal occupies one full etu starting at the stop sample.
                     state_d = RX_NACK;
                     eor_d   = 1'b0;
                     run_d   = 1'b1;
                     nack_d  = 1'b1;
                     cnt_d   = '0;
                  end
               end else if (line != STOP_BIT) begin
                  frm_set = 1'b1;
               end else if (stop2_q) begin
                  state_d = RX_STOP2;
                  eor_d   = 1'b0;
                  run_d   = 1'b1;
               end else begin
                  push = 1'b1;
               end
            end
         end
         RX_STOP2: begin
            if (sample) begin
               state_d = RX_IDLE;
               eor_d   = 1'b1;
               run_d   = 1'b0;
               if (line != STOP_BIT) begin
                  frm_set = 1'b1;
               end else begin
                  push = 1'b1;
               end
            end
         end
         RX_NACK: begin
            if (tick && cnt_last) begin
               state_d = RX_IDLE;
               eor_d   = 1'b1;
               run_d   = 1'b0;
               nack_d  = 1'b0;
            end
         end
         default: begin
            state_d = RX_IDLE;
            run_d   = 1'b0;
            nack_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!nReset) begin
         state_q     <= RX_IDLE;
         cnt_q       <= '0;
         bitn_q      <= '0;
         shift_q     <= '0;
         par_err_q   <= 1'b0;
         run_q       <= 1'b0;
         start_bit_q <= 1'b0;
         eor_q       <= 1'b0;
         nack_q      <= 1'b0;
         ovr_q       <= 1'b0;
         par_q       <= 1'b0;
         frm_q       <= 1'b0;
         cpb_q       <= '0;
         stop2_q     <= 1'b0;
         odd_q       <= 1'b0;
         msb_q       <= 1'b0;
         nacken_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bitn_q      <= bitn_d;
         shift_q     <= shift_d;
         par_err_q   <= par_err_d;
         run_q       <= run_d;
         start_bit_q <= start_bit_d;
         eor_q       <= eor_d;
         nack_q      <= nack_d;
         // A set in the same cycle as an acknowledge wins.
         ovr_q       <= (ovr_q & ~ackFlags) | ovr_set;
         par_q       <= (par_q & ~ackFlags) | par_set;
         frm_q       <= (frm_q & ~ackFlags) | frm_set;
         if (load_cfg) begin
            cpb_q    <= clocksPerBit;
            stop2_q  <= stopBit2;
            odd_q    <= oddParity;
            msb_q    <= msbFirst;
            nacken_q <= nackEnable;
         end
      end
   end

   iso_rx_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .nReset    (nReset),
      .push_i    (push),
      .data_i    (shift_q),
      .pop_i     (rdEn),
      .data_o    (dataOut),
      .valid_o   (dataValid),
      .level_o   (fifoLevel),
      .overrun_o (ovr_set)
   );

   assign serialNackOut    = nack_q;
   assign run              = run_q;
   assign startBit         = start_bit_q;
   assign endOfRx          = eor_q;
   assign overrunErrorFlag = ovr_q;
   assign parityErrorFlag  = par_q;
   assign frameErrorFlag   = frm_q;

endmodule

// File: tb/tb_iso_rx_fifo_core.sv
// tb/tb_iso_rx_fifo_core.sv - directed self-checking bench for iso_rx_fifo_core
module tb_iso_rx_fifo_core;

   localparam int ETU = 372;

   logic        clk = 1'b0;
   logic        nReset;
   logic [0:0]  clkPerCycle;
   logic [12:0] clocksPerBit;
   logic        stopBit2, oddParity, msbFirst, nackEnable, serialIn;
   logic        serialNackOut, rdEn, dataValid, ackFlags;
   logic [7:0]  dataOut;
   logic [2:0]  fifoLevel;
   logic        overrunErrorFlag, parityErrorFlag, frameErrorFlag;
   logic        run, startBit, endOfRx;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int eor_cnt = 0, run_cnt = 0, start_cnt = 0, nack_cnt = 0, nack_rise = 0;
   logic nack_prev = 1'b0;
   int t0, e0, r0, s0, n0;

   iso_rx_fifo_core dut (
      .clk              (clk),
      .nReset           (nReset),
      .clkPerCycle      (clkPerCycle),
      .clocksPerBit     (clocksPerBit),
      .stopBit2         (stopBit2),
      .oddParity        (oddParity),
      .msbFirst         (msbFirst),
      .nackEnable       (nackEnable),
      .serialIn         (serialIn),
      .serialNackOut    (serialNackOut),
      .rdEn             (rdEn),
      .dataOut          (dataOut),
      .dataValid        (dataValid),
      .fifoLevel        (fifoLevel),
      .ackFlags         (ackFlags),
      .overrunErrorFlag (overrunErrorFlag),
      .parityErrorFlag  (parityErrorFlag),
      .frameErrorFlag   (frameErrorFlag),
      .run              (run),
      .startBit         (startBit),
      .endOfRx          (endOfRx)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (endOfRx) eor_cnt <= eor_cnt + 1;
      if (run) run_cnt <= run_cnt + 1;
      if (startBit) start_cnt <= start_cnt + 1;
      if (serialNackOut) nack_cnt <= nack_cnt + 1;
      if (serialNackOut && !nack_prev) nack_rise <= cyc;
      nack_prev <= serialNackOut;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      serialIn = b;
      cycles(ETU);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic pb, input logic s1,
                             input logic s2, input logic msb);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(msb ? d[7-i] : d[i]);
      send_bit(pb);
      send_bit(s1);
      send_bit(s2);
      send_bit(1'b1);
   endtask

   task automatic pulse_ack();
      ackFlags = 1'b1;
      cycles(1);
      ackFlags = 1'b0;
      cycles(1);
   endtask

   task automatic pop();
      rdEn = 1'b1;
      cycles(1);
      rdEn = 1'b0;
   endtask

   initial begin
      logic [7:0] chars [5];
      logic [7:0] pbits;
      chars = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
      pbits = 8'b0000_1011;
      nReset = 1'b0; serialIn = 1'b1; rdEn = 1'b0; ackFlags = 1'b0;
      clkPerCycle = 1'b0; clocksPerBit = 13'd372;
      stopBit2 = 1'b0; oddParity = 1'b0; msbFirst = 1'b0; nackEnable = 1'b1;
      cycles(3);
      check("rst_valid", 32'(dataValid), 32'd0);
      check("rst_level", 32'(fifoLevel), 32'd0);
      check("rst_run", 32'(run), 32'd0);
      check("rst_nack", 32'(serialNackOut), 32'd0);
      check("rst_flags", 32'({overrunErrorFlag, parityErrorFlag, frameErrorFlag}), 32'd0);
      nReset = 1'b1;
      cycles(10);

      // Good character 0x3B, lsb first, even parity -> parity bit 1
      e0 = eor_cnt;
      send_frame(8'h3B, 1'b1, 1'b1, 1'b1, 1'b0);
      check("good_valid", 32'(dataValid), 32'd1);
      check("good_data", 32'(dataOut), 32'h3B);
      check("good_level", 32'(fifoLevel), 32'd1);
      check("good_eor", 32'(eor_cnt - e0), 32'd1);
      check("good_flags", 32'({overrunErrorFlag, parityErrorFlag, frameErrorFlag}), 32'd0);
      pop();
      check("pop_valid", 32'(dataValid), 32'd0);
      check("pop_hold", 32'(dataOut), 32'h3B);
      pop();
      check("empty_pop_level", 32'(fifoLevel), 32'd0);

      // Glitch: start level for 100 ticks only
      e0 = eor_cnt; r0 = run_cnt; s0 = start_cnt;
      serialIn = 1'b0;
      cycles(100);
      serialIn = 1'b1;
      cycles(2 * ETU);
      check("glitch_start", 32'(start_cnt != s0), 32'd1);
      check("glitch_run", 32'(run_cnt - r0), 32'd0);
      check("glitch_eor", 32'(eor_cnt - e0), 32'd0);
      check("glitch_flags", 32'({overrunErrorFlag, parityErrorFlag, frameErrorFlag}), 32'd0);

      // Parity error with error signal
      e0 = eor_cnt; n0 = nack_cnt; t0 = cyc;
      send_frame(8'h3B, 1'b0, 1'b1, 1'b1, 1'b0);
      check("nack_len", 32'(nack_cnt - n0), 32'd372);
      check("nack_rise", 32'((nack_rise - t0) >= 3906 && (nack_rise - t0) <= 3914), 32'd1);
      check("nack_par_flag", 32'(parityErrorFlag), 32'd1);
      check("nack_level", 32'(fifoLevel), 32'd0);
      check("nack_eor", 32'(eor_cnt - e0), 32'd1);
      pulse_ack();
      check("ack_par", 32'(parityErrorFlag), 32'd0);

      // Parity error, error signal disabled
      nackEnable = 1'b0;
      n0 = nack_cnt;
      send_frame(8'h3B, 1'b0, 1'b1, 1'b1, 1'b0);
      check("nonack_len", 32'(nack_cnt - n0), 32'd0);
      check("nonack_flag", 32'(parityErrorFlag), 32'd1);
      check("nonack_level", 32'(fifoLevel), 32'd0);
      pulse_ack();
      nackEnable = 1'b1;

      // Five characters into a four-entry FIFO
      for (int k = 0; k < 5; k++) send_frame(chars[k], pbits[k], 1'b1, 1'b1, 1'b0);
      check("ovr_level", 32'(fifoLevel), 32'd4);
      check("ovr_flag", 32'(overrunErrorFlag), 32'd1);
      check("ovr_head", 32'(dataOut), 32'h01);
      check("ovr_par", 32'(parityErrorFlag), 32'd0);
      pulse_ack();
      check("ovr_ack", 32'(overrunErrorFlag), 32'd0);
      for (int k = 0; k < 4; k++) begin
         check("ovr_order", 32'(dataOut), 32'(chars[k]));
         pop();
      end
      check("ovr_drained", 32'(fifoLevel), 32'd0);

      // Frame error on first stop bit
      e0 = eor_cnt;
      send_frame(8'h55, 1'b0, 1'b0, 1'b1, 1'b0);
      check("frm1_flag", 32'(frameErrorFlag), 32'd1);
      check("frm1_level", 32'(fifoLevel), 32'd0);
      check("frm1_eor", 32'(eor_cnt - e0), 32'd1);
      pulse_ack();
      check("frm1_ack", 32'(frameErrorFlag), 32'd0);

      // Two stop bits, second one low
      stopBit2 = 1'b1;
      send_frame(8'h55, 1'b0, 1'b1, 1'b0, 1'b0);
      check("frm2_flag", 32'(frameErrorFlag), 32'd1);
      check("frm2_level", 32'(fifoLevel), 32'd0);
      pulse_ack();
      stopBit2 = 1'b0;

      // Reset in the middle of data bit 4
      e0 = eor_cnt;
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      serialIn = 1'b0;
      cycles(186);
      check("mid_run", 32'(run), 32'd1);
      nReset = 1'b0;
      serialIn = 1'b1;
      cycles(1);
      check("mid_rst_run", 32'(run), 32'd0);
      check("mid_rst_start", 32'(startBit), 32'd0);
      check("mid_rst_data", 32'(dataOut), 32'd0);
      check("mid_rst_valid", 32'(dataValid), 32'd0);
      check("mid_rst_flags", 32'({overrunErrorFlag, parityErrorFlag, frameErrorFlag}), 32'd0);
      nReset = 1'b1;
      cycles(2 * ETU);
      check("mid_rst_eor", 32'(eor_cnt - e0), 32'd0);

      // Recovery frame, msb first: 0xA5 has four ones -> parity bit 0
      msbFirst = 1'b1;
      e0 = eor_cnt;
      send_frame(8'hA5, 1'b0, 1'b1, 1'b1, 1'b1);
      check("msb_data", 32'(dataOut), 32'hA5);
      check("msb_level", 32'(fifoLevel), 32'd1);
      check("msb_eor", 32'(eor_cnt - e0), 32'd1);
      check("msb_flags", 32'({overrunErrorFlag, parityErrorFlag, frameErrorFlag}), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
